// File: rtl/qft4_stream.sv
// qft4_stream -- streaming 4-point DFT / QFT engine.
//
// Buffers a frame of four signed complex samples, runs a two-stage radix-2
// butterfly (twiddles are only +-1 and +-j, so no multipliers), then returns
// X[0..3] serially in natural order over a valid/ready handshake.
//
// Optional build macro: QFT_NORM_EN
//   defined   - outputs scaled by 1/2 (unitary 4-point QFT), (v+1)>>>1 rounding
//   undefined - exact, unscaled DFT outputs
//
// Parameters:
//   DATA_W  input real/imag width (signed)
//   OUT_W   output real/imag width (signed), must be >= DATA_W+2
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   inv        0 = forward (W = -j), 1 = inverse (W = +j); taken with sample 0
//   in_valid   input sample valid
//   in_ready   engine accepts a sample (LOAD only)
//   in_re/im   input sample
//   out_valid  output sample valid (UNLOAD only)
//   out_ready  downstream accepts output
//   out_re/im  output bin X[k]
//   out_idx    bin index k
//   out_last   high with k = 3
//   busy       engine holds or processes a frame
//
// state  | meaning
// -------+-----------------------------------------------
// LOAD   | accepting x[0..3]; cnt_q = samples held
// BFLY1  | first butterfly stage registers a0..a3
// BFLY2  | second stage registers X0..X3
// UNLOAD | presenting X[idx_q], advance on out handshake

module qft4_stream #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inv,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic [1:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int A_W = DATA_W + 1;
  localparam int B_W = DATA_W + 2;

  if (OUT_W < DATA_W + 2) begin : g_bad_out_w
    $error("qft4_stream: OUT_W must be >= DATA_W+2");
  end

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_BFLY1  = 2'd1,
    S_BFLY2  = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       inv_q, inv_d;

  logic signed [DATA_W-1:0] xr_q [4];
  logic signed [DATA_W-1:0] xi_q [4];
  logic signed [A_W-1:0]    ar_q [4];
  logic signed [A_W-1:0]    ai_q [4];
  logic signed [A_W-1:0]    ar_d [4];
  logic signed [A_W-1:0]    ai_d [4];
  logic signed [OUT_W-1:0]  yr_q [4];
  logic signed [OUT_W-1:0]  yi_q [4];
  logic signed [OUT_W-1:0]  yr_d [4];
  logic signed [OUT_W-1:0]  yi_d [4];

  // Forward-direction odd-bin terms; the inverse swaps X1 and X3.
  logic signed [B_W-1:0] x0r, x0i, x2r, x2i;
  logic signed [B_W-1:0] f1r, f1i, f3r, f3i;

  // Sign-extend a stage-2 result to the output width, optionally halving it.
  // The +1 cannot overflow: |v| <= 2^(DATA_W+1) fits OUT_W with headroom.
  function automatic logic signed [OUT_W-1:0] finish_val(input logic signed [B_W-1:0] v);
    logic signed [OUT_W-1:0] e;
    e = OUT_W'(v);
`ifdef QFT_NORM_EN
    e = (e + OUT_W'(1)) >>> 1;
`endif
    return e;
  endfunction

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) inv_d = inv;
          if (cnt_q == 2'd3) state_d = S_BFLY1;
        end
      end
      S_BFLY1: state_d = S_BFLY2;
      S_BFLY2: begin
        state_d = S_UNLOAD;
        idx_d   = 2'd0;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_comb begin
    ar_d[0] = A_W'(xr_q[0]) + A_W'(xr_q[2]);
    ai_d[0] = A_W'(xi_q[0]) + A_W'(xi_q[2]);
    ar_d[1] = A_W'(xr_q[0]) - A_W'(xr_q[2]);
    ai_d[1] = A_W'(xi_q[0]) - A_W'(xi_q[2]);
    ar_d[2] = A_W'(xr_q[1]) + A_W'(xr_q[3]);
    ai_d[2] = A_W'(xi_q[1]) + A_W'(xi_q[3]);
    ar_d[3] = A_W'(xr_q[1]) - A_W'(xr_q[3]);
    ai_d[3] = A_W'(xi_q[1]) - A_W'(xi_q[3]);
  end

  always_comb begin
    x0r = B_W'(ar_q[0]) + B_W'(ar_q[2]);
    x0i = B_W'(ai_q[0]) + B_W'(ai_q[2]);
    x2r = B_W'(ar_q[0]) - B_W'(ar_q[2]);
    x2i = B_W'(ai_q[0]) - B_W'(ai_q[2]);
    // (a1) + W*(a3) with W = -j  ->  (a1r + a3i) + j(a1i - a3r)
    f1r = B_W'(ar_q[1]) + B_W'(ai_q[3]);
    f1i = B_W'(ai_q[1]) - B_W'(ar_q[3]);
    f3r = B_W'(ar_q[1]) - B_W'(ai_q[3]);
    f3i = B_W'(ai_q[1]) + B_W'(ar_q[3]);

    yr_d[0] = finish_val(x0r);
    yi_d[0] = finish_val(x0i);
    yr_d[2] = finish_val(x2r);
    yi_d[2] = finish_val(x2i);
    yr_d[1] = finish_val(inv_q ? f3r : f1r);
    yi_d[1] = finish_val(inv_q ? f3i : f1i);
    yr_d[3] = finish_val(inv_q ? f1r : f3r);
    yi_d[3] = finish_val(inv_q ? f1i : f3i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        xr_q[i] <= '0;
        xi_q[i] <= '0;
        ar_q[i] <= '0;
        ai_q[i] <= '0;
        yr_q[i] <= '0;
        yi_q[i] <= '0;
      end
    end else begin
      if (state_q == S_LOAD && in_valid) begin
        xr_q[cnt_q] <= in_re;
        xi_q[cnt_q] <= in_im;
      end
      if (state_q == S_BFLY1) begin
        for (int i = 0; i < 4; i++) begin
          ar_q[i] <= ar_d[i];
          ai_q[i] <= ai_d[i];
        end
      end
      if (state_q == S_BFLY2) begin
        for (int i = 0; i < 4; i++) begin
          yr_q[i] <= yr_d[i];
          yi_q[i] <= yi_d[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign out_re   = out_valid ? yr_q[idx_q] : '0;
  assign out_im   = out_valid ? yi_q[idx_q] : '0;
  assign out_idx  = idx_q;
  assign out_last = out_valid && (idx_q == 2'd3);
  assign busy     = (state_q != S_LOAD) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_qft4_stream.sv
// Directed bench for qft4_stream (DATA_W=8, OUT_W=13). Expected values are
// hand-computed unscaled DFT bins; when QFT_NORM_EN is defined they are
// passed through the same (v+1)>>>1 rounding the normalised build applies.
module tb_qft4_stream;

  localparam int DW = 8;
  localparam int OW = 13;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 inv = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [1:0]           out_idx;
  logic                 out_last;
  logic                 busy;

  int n_chk = 0;
  int n_pass = 0;

  qft4_stream #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .inv(inv),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   re [4];
    int   im [4];
    logic inv0;      // inv during sample 0
    logic inv_rest;  // inv during samples 1..3 (must be ignored)
    int   er [4];
    int   ei [4];
  } vec_t;

  vec_t vt [7];
  vec_t v_rst;

  function automatic int expv(input int v);
`ifdef QFT_NORM_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input int re, input int im, input logic inv_v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_re = DW'(re);
    in_im = DW'(im);
    inv = inv_v;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("push timeout", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input int k, input int er, input int ei);
    int t;
    t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("%s pop timeout k%0d", tag, k), int'(out_valid), 1);
    check($sformatf("%s k%0d re", tag, k), int'(out_re), expv(er));
    check($sformatf("%s k%0d im", tag, k), int'(out_im), expv(ei));
    check($sformatf("%s k%0d idx", tag, k), int'(out_idx), k);
    check($sformatf("%s k%0d last", tag, k), int'(out_last), (k == 3) ? 1 : 0);
    check($sformatf("%s k%0d in_ready", tag, k), int'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    for (int n = 0; n < 4; n++) push(v.re[n], v.im[n], (n == 0) ? v.inv0 : v.inv_rest);
    // Now just after the edge that accepted x3: two more edges to out_valid.
    check({tag, " lat0"}, int'(out_valid), 0);
    check({tag, " busy"}, int'(busy), 1);
    @(negedge clk);
    check({tag, " lat1"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, " lat2"}, int'(out_valid), 1);
    for (int k = 0; k < 4; k++) pop(tag, k, v.er[k], v.ei[k]);
    check({tag, " in_ready after k3"}, int'(in_ready), 1);
    check({tag, " out_valid after k3"}, int'(out_valid), 0);
  endtask

  initial begin
    vt[0] = '{re:'{2, 4, 6, 8}, im:'{0, 0, 0, 0}, inv0:1'b0, inv_rest:1'b0,
              er:'{20, -4, -4, -4}, ei:'{0, 4, 0, -4}};
    vt[1] = '{re:'{2, 4, 6, 8}, im:'{0, 0, 0, 0}, inv0:1'b1, inv_rest:1'b1,
              er:'{20, -4, -4, -4}, ei:'{0, -4, 0, 4}};
    vt[2] = '{re:'{-128, -128, -128, -128}, im:'{-128, -128, -128, -128}, inv0:1'b0, inv_rest:1'b0,
              er:'{-512, 0, 0, 0}, ei:'{-512, 0, 0, 0}};
    vt[3] = '{re:'{1, 0, 0, 0}, im:'{0, 0, 0, 0}, inv0:1'b0, inv_rest:1'b0,
              er:'{1, 1, 1, 1}, ei:'{0, 0, 0, 0}};
    vt[4] = '{re:'{0, 1, 0, 0}, im:'{0, 0, 0, 0}, inv0:1'b0, inv_rest:1'b1,
              er:'{1, 0, -1, 0}, ei:'{0, -1, 0, 1}};
    vt[5] = '{re:'{0, 0, 0, 0}, im:'{0, 1, 0, 0}, inv0:1'b1, inv_rest:1'b0,
              er:'{0, -1, 0, 1}, ei:'{1, 0, -1, 0}};
    vt[6] = '{re:'{127, -128, 127, -128}, im:'{-128, 127, -128, 127}, inv0:1'b0, inv_rest:1'b0,
              er:'{-2, 0, 510, 0}, ei:'{-2, 0, -510, 0}};
    v_rst = '{re:'{1, 1, 1, 1}, im:'{0, 0, 0, 0}, inv0:1'b0, inv_rest:1'b0,
              er:'{4, 0, 0, 0}, ei:'{0, 0, 0, 0}};

    #12;
    check("rst in_ready", int'(in_ready), 1);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_re", int'(out_re), 0);
    check("rst out_im", int'(out_im), 0);
    check("rst out_idx", int'(out_idx), 0);
    check("rst out_last", int'(out_last), 0);
    check("rst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Backpressure: each bin stalls two cycles; in_valid is driven during
    // UNLOAD with junk and must be ignored.
    for (int n = 0; n < 4; n++) push(vt[0].re[n], vt[0].im[n], 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("bp valid", int'(out_valid), 1);
    in_valid = 1'b1;
    in_re = 8'sd99;
    in_im = -8'sd77;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check($sformatf("bp stall k%0d re", k), int'(out_re), expv(vt[0].er[k]));
        check($sformatf("bp stall k%0d im", k), int'(out_im), expv(vt[0].ei[k]));
        check($sformatf("bp stall k%0d idx", k), int'(out_idx), k);
        check($sformatf("bp stall k%0d in_ready", k), int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("bp done out_valid", int'(out_valid), 0);
    check("bp done in_ready", int'(in_ready), 1);
    check("bp no stray sample", int'(busy), 0);
    run_frame(vt[4], "post-bp");

    // Reset after two samples; the stale samples must not leak into the next frame.
    push(100, 50, 1'b1);
    push(-7, 33, 1'b1);
    check("mid-load busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid-load rst busy", int'(busy), 0);
    check("mid-load rst in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(v_rst, "after-rst");

    // Reset during UNLOAD drops out_valid at once.
    for (int n = 0; n < 4; n++) push(vt[0].re[n], vt[0].im[n], 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("mid-unload valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid-unload rst valid", int'(out_valid), 0);
    check("mid-unload rst out_re", int'(out_re), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vt[1], "after-rst2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
